// File: rtl/kypd_scan_ctrl_pkg.sv
// kypd_pkg: shared constants, key map and scan-state type for the
// 4x4 keypad scan controller.
package kypd_pkg;

    localparam int KEY_W    = 4;
    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

    // Key legend, indexed {row,col}, rows top-down, columns left-right.
    localparam logic [KEY_W-1:0] KEY_MAP [0:NUM_KEYS-1] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'h0, 4'hF, 4'hE, 4'hD
    };

    typedef enum logic {
        SCAN_COL,
        SCAN_EVAL
    } scan_state_e;

    // Number of keys down in a frame.
    function automatic logic [4:0] key_count(input logic [NUM_KEYS-1:0] f);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            n = n + {4'd0, f[i]};
        end
        return n;
    endfunction

    // Legend of a key down in a frame; frames are laid out {col,row}.
    function automatic logic [KEY_W-1:0] frame_code(input logic [NUM_KEYS-1:0] f);
        logic [KEY_W-1:0] code;
        code = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                if (f[c*NUM_ROWS + r]) begin
                    code = KEY_MAP[r*NUM_COLS + c];
                end
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/kypd_scan_ctrl_if.sv
// kypd_scan_ctrl_if: key event valid/ready channel from the
// scan controller to the code-entry logic.
interface kypd_scan_ctrl_if;
    import kypd_pkg::*;

    logic             key_valid;
    logic [KEY_W-1:0] key_code;
    logic             key_ready;

    modport master (output key_valid, output key_code, input key_ready);
    modport slave  (input key_valid, input key_code, output key_ready);

endinterface

// File: rtl/kypd_scan_ctrl_debounce.sv
// kypd_debounce: accepts a frame once it has been seen unchanged for
// DEBOUNCE_SCANS consecutive scans; pulses upd_o when the stable frame changes.
module kypd_debounce
    import kypd_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] frame_i,
    input  logic                strobe_i,
    output logic [NUM_KEYS-1:0] stable_o,
    output logic                upd_o
);

    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_SCANS);

    logic [NUM_KEYS-1:0] prev_q, prev_d;
    logic [NUM_KEYS-1:0] stable_q, stable_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                upd_q, upd_d;

    // Count identical frames and promote one to stable when the run is long enough.
    always_comb begin
        prev_d   = prev_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        upd_d    = 1'b0;
        if (strobe_i) begin
            prev_d = frame_i;
            if (frame_i == prev_q) begin
                cnt_d = (cnt_q == CMAX) ? cnt_q : cnt_q + 1'b1;
            end else begin
                cnt_d = CW'(1);
            end
            if (cnt_d == CMAX && frame_i != stable_q) begin
                stable_d = frame_i;
                upd_d    = 1'b1;
            end
        end
    end

    // Debounce history registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q   <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
            upd_q    <= 1'b0;
        end else begin
            prev_q   <= prev_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            upd_q    <= upd_d;
        end
    end

    assign stable_o = stable_q;
    assign upd_o    = upd_q;

endmodule

// File: rtl/kypd_scan_ctrl.sv
// kypd_scan_ctrl: 4x4 keypad column scanner, debouncer and key-event source.
// Define KYPD_DIGIT_SHIFT_EN to add the num digit shift register output.
module kypd_scan_ctrl
    import kypd_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic [NUM_COLS-1:0]      col_n,
    input  logic [NUM_ROWS-1:0]      row_n,
    kypd_scan_ctrl_if.master         kif,
    output logic                     key_held,
    output logic                     multi_err,
    output logic                     overrun
`ifdef KYPD_DIGIT_SHIFT_EN
    ,
    output logic [27:0]              num
`endif
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE_CYCLES - 1);

    logic [NUM_ROWS-1:0] sync1_q, sync2_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [1:0]          col_q, col_d;
    logic [NUM_KEYS-1:0] frame_q, frame_d;
    scan_state_e         state_q, state_d;

    logic [NUM_KEYS-1:0] stable;
    logic                upd;

    logic [NUM_KEYS-1:0] last_q, last_d;
    logic                held_q, held_d;
    logic                multi_q, multi_d;
    logic                ovr_q, ovr_d;
    logic                valid_q, valid_d;
    logic [KEY_W-1:0]    code_q, code_d;
    logic [4:0]          pop;
    logic                ev;
    logic                accept;

    // Two-flop synchroniser for the asynchronous row lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= row_n;
            sync2_q <= sync1_q;
        end
    end

    // Column window timing, row sampling and end-of-frame evaluation flag.
    always_comb begin
        state_d = SCAN_COL;
        cnt_d   = cnt_q + 1'b1;
        col_d   = col_q;
        frame_d = frame_q;
        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            col_d = col_q + 2'd1;
            for (int r = 0; r < NUM_ROWS; r++) begin
                frame_d[int'(col_q)*NUM_ROWS + r] = ~sync2_q[r];
            end
            if (col_q == 2'd3) begin
                state_d = SCAN_EVAL;
            end
        end
    end

    // Scan state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SCAN_COL;
            cnt_q   <= '0;
            col_q   <= '0;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
            frame_q <= frame_d;
        end
    end

    assign col_n = ~(4'b0001 << col_q);

    kypd_debounce #(
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_debounce (
        .clk      (clk),
        .rst_n    (rst_n),
        .frame_i  (frame_q),
        .strobe_i (state_q == SCAN_EVAL),
        .stable_o (stable),
        .upd_o    (upd)
    );

    assign pop    = key_count(stable);
    assign ev     = upd && (last_q == '0) && (pop == 5'd1);
    assign accept = valid_q && kif.key_ready;

    // Event detection and the one-entry handshake buffer.
    always_comb begin
        last_d  = last_q;
        held_d  = held_q;
        multi_d = 1'b0;
        ovr_d   = 1'b0;
        valid_d = valid_q;
        code_d  = code_q;
        if (upd) begin
            last_d  = stable;
            held_d  = (pop == 5'd1);
            multi_d = (pop >= 5'd2);
        end
        if (ev) begin
            if (!valid_q || accept) begin
                valid_d = 1'b1;
                code_d  = frame_code(stable);
            end else begin
                ovr_d = 1'b1;
            end
        end else if (accept) begin
            valid_d = 1'b0;
        end
    end

    // Event and handshake registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q  <= '0;
            held_q  <= 1'b0;
            multi_q <= 1'b0;
            ovr_q   <= 1'b0;
            valid_q <= 1'b0;
            code_q  <= '0;
        end else begin
            last_q  <= last_d;
            held_q  <= held_d;
            multi_q <= multi_d;
            ovr_q   <= ovr_d;
            valid_q <= valid_d;
            code_q  <= code_d;
        end
    end

    assign kif.key_valid = valid_q;
    assign kif.key_code  = code_q;
    assign key_held      = held_q;
    assign multi_err     = multi_q;
    assign overrun       = ovr_q;

`ifdef KYPD_DIGIT_SHIFT_EN
    logic [27:0] num_q, num_d;

    // Shift accepted digits in from the right; F clears the number.
    always_comb begin
        num_d = num_q;
        if (accept) begin
            num_d = (code_q == 4'hF) ? 28'h0 : {num_q[23:0], code_q};
        end
    end

    // Digit shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_q <= '0;
        end else begin
            num_q <= num_d;
        end
    end

    assign num = num_q;
`endif

endmodule
